// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with persistent flags, shifts and a shift-add multiplier
//
// Purpose: WIDTH-bit ALU between decode and writeback. Single-cycle ops finish
// one edge after acceptance; MUL runs one multiplier bit per cycle (LSB first)
// and finishes WIDTH+1 edges after acceptance. Flags {Z,N,C,V} persist across
// operations and feed the carry-in of ADC.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   request present          in_ready  request accepted this edge
//   op/a/b     opcode and operands, captured on acceptance
//   out_valid  result/flags valid (DONE) out_ready consumer takes the result
//   result     registered result        flags     registered {Z,N,C,V}
module alu_seq #(
  parameter int WIDTH = 4,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);
  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_PAS = 4'd6;
  localparam logic [3:0] OP_ADC = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;
  localparam logic [3:0] OP_SAR = 4'd10;
  localparam logic [3:0] OP_MUL = 4'd11;
  localparam logic [3:0] OP_CMP = 4'd12;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [3:0]         flags_q, flags_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic               accept;
  logic               c_flag;
  logic [WIDTH:0]     add_ext;
  logic [WIDTH:0]     sub_ext;
  logic [SHW-1:0]     shamt;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;

  assign c_flag    = flags_q[1];
  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign flags     = flags_q;
  assign shamt     = b[SHW-1:0];

  // One adder serves ADD and ADC; carry-in is the stored C only for ADC.
  assign add_ext = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (op == OP_ADC) & c_flag};
  // Extended subtract: the top bit is the unsigned borrow (a < b).
  assign sub_ext = {1'b0, a} - {1'b0, b};

  // Single-cycle datapath; C defaults to the stored flag so logic/shift ops keep it.
  always_comb begin
    alu_res = '0;
    alu_c   = c_flag;
    alu_v   = 1'b0;
    case (op)
      OP_ADD, OP_ADC: begin
        alu_res = add_ext[WIDTH-1:0];
        alu_c   = add_ext[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        alu_res = sub_ext[WIDTH-1:0];
        alu_c   = sub_ext[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOT:  alu_res = ~a;
      OP_PAS:  alu_res = a;
      OP_SHL:  alu_res = a << shamt;
      OP_SHR:  alu_res = a >> shamt;
      OP_SAR:  alu_res = $signed(a) >>> shamt;
      default: alu_res = '0;  // MUL goes through the sequencer; reserved ops yield 0
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;

    case (state_q)
      S_IDLE: state_d = S_IDLE;
      S_BUSY: begin
        // WIDTH iterations, then one extra edge to publish the product.
        if (cnt_q == CNT_LAST) begin
          state_d  = S_DONE;
          result_d = acc_q[WIDTH-1:0];
          flags_d  = {(acc_q[WIDTH-1:0] == '0), acc_q[WIDTH-1],
                      |acc_q[2*WIDTH-1:WIDTH], 1'b0};
        end else begin
          if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Acceptance is only possible from IDLE or a draining DONE, so it
    // overrides whatever those states chose above.
    if (accept) begin
      if (op == OP_MUL) begin
        state_d  = S_BUSY;
        acc_d    = '0;
        mcand_d  = {{WIDTH{1'b0}}, a};
        mplier_d = b;
        cnt_d    = '0;
      end else begin
        state_d  = S_DONE;
        result_d = alu_res;
        flags_d  = {(alu_res == '0), alu_res[WIDTH-1], alu_c, alu_v};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      flags_q  <= 4'b0000;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq at WIDTH=8
module tb_alu_seq;
  localparam int W = 8;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_PAS = 4'd6;
  localparam logic [3:0] OP_ADC = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;
  localparam logic [3:0] OP_SAR = 4'd10;
  localparam logic [3:0] OP_MUL = 4'd11;
  localparam logic [3:0] OP_CMP = 4'd12;

  typedef struct packed {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [3:0]   fl;
  } vec_t;

  logic         clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]   op, flags;
  logic [W-1:0] a, b, result;

  int tests_run    = 0;
  int tests_failed = 0;

  vec_t sv[18];
  vec_t mv[3];

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic test_reset;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = 4'd0; a = '0; b = '0;
    #1 rst = 1'b1;
    #1;
    tests_run++; if (result !== 8'h00) begin tests_failed++; $display("FAIL reset_result: got %h expected 00", result); end
    tests_run++; if (flags !== 4'b0000) begin tests_failed++; $display("FAIL reset_flags: got %b expected 0000", flags); end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_release_out_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_add_adc;
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; op = OP_ADD; a = 8'hFF; b = 8'h01;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL add_pre_out_valid: got %b expected 0", out_valid); end
    @(negedge clk);
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL add_out_valid: got %b expected 1", out_valid); end
    tests_run++; if (result !== 8'h00) begin tests_failed++; $display("FAIL add_result: got %h expected 00", result); end
    tests_run++; if (flags !== 4'b1010) begin tests_failed++; $display("FAIL add_flags: got %b expected 1010", flags); end
    op = OP_ADC; a = 8'h00; b = 8'h00;
    @(negedge clk);
    tests_run++; if (result !== 8'h01) begin tests_failed++; $display("FAIL adc_result: got %h expected 01", result); end
    tests_run++; if (flags !== 4'b0000) begin tests_failed++; $display("FAIL adc_flags: got %b expected 0000", flags); end
    in_valid = 1'b0;
    @(negedge clk);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL adc_drain_out_valid: got %b expected 0", out_valid); end
    tests_run++; if (flags !== 4'b0000) begin tests_failed++; $display("FAIL adc_persist_flags: got %b expected 0000", flags); end
  endtask

  // Back-to-back single-cycle ops; flags expectations follow the chain of C.
  task automatic test_single_ops;
    sv[0]  = '{OP_SUB, 8'h80, 8'h01, 8'h7F, 4'b0001};
    sv[1]  = '{OP_SAR, 8'h90, 8'h03, 8'hF2, 4'b0100};
    sv[2]  = '{OP_ADD, 8'h7F, 8'h01, 8'h80, 4'b0101};
    sv[3]  = '{OP_SUB, 8'h00, 8'h01, 8'hFF, 4'b0110};
    sv[4]  = '{OP_AND, 8'hF0, 8'h3C, 8'h30, 4'b0010};
    sv[5]  = '{OP_OR,  8'h00, 8'h00, 8'h00, 4'b1010};
    sv[6]  = '{OP_XOR, 8'hAA, 8'hFF, 8'h55, 4'b0010};
    sv[7]  = '{OP_NOT, 8'h0F, 8'h00, 8'hF0, 4'b0110};
    sv[8]  = '{OP_PAS, 8'h80, 8'h00, 8'h80, 4'b0110};
    sv[9]  = '{OP_SHL, 8'h81, 8'h01, 8'h02, 4'b0010};
    sv[10] = '{OP_SHR, 8'h81, 8'h00, 8'h81, 4'b0110};
    sv[11] = '{OP_CMP, 8'h05, 8'h07, 8'hFE, 4'b0110};
    sv[12] = '{4'd13,  8'h12, 8'h34, 8'h00, 4'b1010};
    sv[13] = '{OP_CMP, 8'h07, 8'h07, 8'h00, 4'b1000};
    sv[14] = '{4'd15,  8'hFF, 8'hFF, 8'h00, 4'b1000};
    sv[15] = '{OP_ADD, 8'hFF, 8'hFF, 8'hFE, 4'b0110};
    sv[16] = '{OP_SHR, 8'h80, 8'h07, 8'h01, 4'b0010};
    sv[17] = '{OP_SAR, 8'h80, 8'h07, 8'hFF, 4'b0110};
    out_ready = 1'b1;
    for (int i = 0; i <= 18; i++) begin
      @(negedge clk);
      if (i > 0) begin
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL vec%0d_out_valid: got %b expected 1", i - 1, out_valid); end
        tests_run++; if (result !== sv[i-1].res) begin tests_failed++; $display("FAIL vec%0d_result: got %h expected %h", i - 1, result, sv[i-1].res); end
        tests_run++; if (flags !== sv[i-1].fl) begin tests_failed++; $display("FAIL vec%0d_flags: got %b expected %b", i - 1, flags, sv[i-1].fl); end
      end
      if (i < 18) begin
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL vec%0d_in_ready: got %b expected 1", i, in_ready); end
        in_valid = 1'b1; op = sv[i].op; a = sv[i].a; b = sv[i].b;
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL vec_drain_out_valid: got %b expected 0", out_valid); end
  endtask

  // MUL latency (including by 0 and 1), in_ready low while busy, ignored requests.
  task automatic test_mul;
    mv[0] = '{OP_MUL, 8'd20, 8'd15, 8'h2C, 4'b0010};
    mv[1] = '{OP_MUL, 8'hAB, 8'h01, 8'hAB, 4'b0100};
    mv[2] = '{OP_MUL, 8'h37, 8'h00, 8'h00, 4'b1000};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; op = mv[i].op; a = mv[i].a; b = mv[i].b;
      @(posedge clk);
      for (int j = 0; j <= 9; j++) begin
        @(negedge clk);
        tests_run++; if (out_valid !== logic'(j == 9)) begin tests_failed++; $display("FAIL mul%0d_out_valid_c%0d: got %b expected %b", i, j, out_valid, j == 9); end
        tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL mul%0d_in_ready_c%0d: got %b expected 0", i, j, in_ready); end
        if (j == 0) begin
          op = OP_ADD; a = 8'h01; b = 8'h01;
        end
      end
      tests_run++; if (result !== mv[i].res) begin tests_failed++; $display("FAIL mul%0d_result: got %h expected %h", i, result, mv[i].res); end
      tests_run++; if (flags !== mv[i].fl) begin tests_failed++; $display("FAIL mul%0d_flags: got %b expected %b", i, flags, mv[i].fl); end
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL mul%0d_drain_out_valid: got %b expected 0", i, out_valid); end
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; op = OP_ADD; a = 8'h10; b = 8'h20;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL stall%0d_out_valid: got %b expected 1", i, out_valid); end
      tests_run++; if (result !== 8'h30) begin tests_failed++; $display("FAIL stall%0d_result: got %h expected 30", i, result); end
      tests_run++; if (flags !== 4'b0000) begin tests_failed++; $display("FAIL stall%0d_flags: got %b expected 0000", i, flags); end
      tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL stall%0d_in_ready: got %b expected 0", i, in_ready); end
      op = OP_XOR; a = 8'hFF; b = 8'h0F;
    end
    out_ready = 1'b1;
    #1;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    tests_run++; if (result !== 8'hF0) begin tests_failed++; $display("FAIL b2b_xor_result: got %h expected f0", result); end
    tests_run++; if (flags !== 4'b0100) begin tests_failed++; $display("FAIL b2b_xor_flags: got %b expected 0100", flags); end
    op = OP_ADD; a = 8'h03; b = 8'h04;
    @(negedge clk);
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL b2b_add_out_valid: got %b expected 1", out_valid); end
    tests_run++; if (result !== 8'h07) begin tests_failed++; $display("FAIL b2b_add_result: got %h expected 07", result); end
    in_valid = 1'b0;
    @(negedge clk);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_drain_out_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_mid_mul;
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; op = OP_SUB; a = 8'h00; b = 8'h01;
    @(negedge clk);
    tests_run++; if (result !== 8'hFF) begin tests_failed++; $display("FAIL pre_rst_result: got %h expected ff", result); end
    tests_run++; if (flags !== 4'b0110) begin tests_failed++; $display("FAIL pre_rst_flags: got %b expected 0110", flags); end
    op = OP_MUL; a = 8'd20; b = 8'd15;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests_run++; if (result !== 8'h00) begin tests_failed++; $display("FAIL midrst_result: got %h expected 00", result); end
    tests_run++; if (flags !== 4'b0000) begin tests_failed++; $display("FAIL midrst_flags: got %b expected 0000", flags); end
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL stale_out_valid_c%0d: got %b expected 0", i, out_valid); end
    end
    in_valid = 1'b1; op = OP_ADD; a = 8'd3; b = 8'd4;
    @(negedge clk);
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL postrst_out_valid: got %b expected 1", out_valid); end
    tests_run++; if (result !== 8'h07) begin tests_failed++; $display("FAIL postrst_result: got %h expected 07", result); end
    tests_run++; if (flags !== 4'b0000) begin tests_failed++; $display("FAIL postrst_flags: got %b expected 0000", flags); end
    in_valid = 1'b0;
    @(negedge clk);
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL postrst_drain_out_valid: got %b expected 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_add_adc();
    test_single_ops();
    test_mul();
    test_back_to_back();
    test_reset_mid_mul();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
